// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared state encoding and result flag bit positions
package alu_seq_pkg;

    typedef enum logic [2:0] {
        S_LOAD_OP = 3'd0,
        S_LOAD_A  = 3'd1,
        S_LOAD_B  = 3'd2,
        S_EXEC    = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

endpackage

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - loads opcode/A/B words, runs one ALU cycle, holds result until consumed
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         clear_carry,
    output logic [W-1:0] alu_opcode,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic         alu_carry_in,
    input  logic [W-1:0] alu_result,
    input  logic         alu_carry_out,
    input  logic         alu_overflow,
    input  logic         alu_negative,
    input  logic         alu_zero,
    output logic [W-1:0] res_data,
    output logic [3:0]   res_flags,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] op_count,
    output logic         busy
);

    state_t       r_state;
    state_t       w_next;
    logic         w_in_ready;
    logic         w_busy;
    logic         w_hs;
    logic [W-1:0] r_opcode;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic         r_carry;
    logic [W-1:0] r_res_data;
    logic [3:0]   r_res_flags;
    logic         r_res_valid;
    logic [W-1:0] r_op_count;

    assign w_hs = in_valid & w_in_ready;

    always_comb begin
        w_next     = r_state;
        w_in_ready = (r_state == S_LOAD_OP) || (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
        w_busy     = (r_state != S_LOAD_OP);
        case (r_state)
            S_LOAD_OP: if (w_hs) w_next = S_LOAD_A;
            S_LOAD_A:  if (w_hs) w_next = S_LOAD_B;
            S_LOAD_B:  if (w_hs) w_next = S_EXEC;
            S_EXEC:    w_next = S_HOLD;
            S_HOLD:    if (r_res_valid && res_ready) w_next = S_LOAD_OP;
            default:   w_next = S_LOAD_OP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_LOAD_OP;
            r_opcode    <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_res_data  <= '0;
            r_res_flags <= '0;
            r_res_valid <= 1'b0;
            r_op_count  <= '0;
        end else begin
            r_state <= w_next;
            if (clear_carry) r_carry <= 1'b0;
            case (r_state)
                S_LOAD_OP: if (w_hs) r_opcode <= in_data;
                S_LOAD_A:  if (w_hs) r_a <= in_data;
                S_LOAD_B:  if (w_hs) r_b <= in_data;
                S_EXEC: begin
                    r_res_data          <= alu_result;
                    r_res_flags[FLAG_C] <= alu_carry_out;
                    r_res_flags[FLAG_V] <= alu_overflow;
                    r_res_flags[FLAG_N] <= alu_negative;
                    r_res_flags[FLAG_Z] <= alu_zero;
                    // The flag word still reports the ALU carry even when the register is cleared
                    r_carry             <= clear_carry ? 1'b0 : alu_carry_out;
                    r_op_count          <= r_op_count + 1'b1;
                    r_res_valid         <= 1'b1;
                end
                S_HOLD:    if (res_ready) r_res_valid <= 1'b0;
                default:   ;
            endcase
        end
    end

    assign in_ready     = w_in_ready;
    assign busy         = w_busy;
    assign alu_opcode   = r_opcode;
    assign alu_a        = r_a;
    assign alu_b        = r_b;
    assign alu_carry_in = r_carry;
    assign res_data     = r_res_data;
    assign res_flags    = r_res_flags;
    assign res_valid    = r_res_valid;
    assign op_count     = r_op_count;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed scoreboard bench for alu_sequencer with an add-with-carry ALU
module tb_alu_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         clear_carry = 1'b0;
    logic [W-1:0] alu_opcode, alu_a, alu_b;
    logic         alu_carry_in;
    logic [W-1:0] alu_result;
    logic         alu_carry_out, alu_overflow, alu_negative, alu_zero;
    logic [W-1:0] res_data;
    logic [3:0]   res_flags;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] op_count;
    logic         busy;

    always #5 clk = ~clk;

    logic [W:0] w_sum;
    assign w_sum         = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_carry_in};
    assign alu_result    = w_sum[W-1:0];
    assign alu_carry_out = w_sum[W];
    assign alu_overflow  = (alu_a[W-1] == alu_b[W-1]) && (w_sum[W-1] != alu_a[W-1]);
    assign alu_negative  = w_sum[W-1];
    assign alu_zero      = (w_sum[W-1:0] == '0);

    alu_sequencer #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .clear_carry(clear_carry),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in),
        .alu_result(alu_result), .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow),
        .alu_negative(alu_negative), .alu_zero(alu_zero),
        .res_data(res_data), .res_flags(res_flags), .res_valid(res_valid), .res_ready(res_ready),
        .op_count(op_count), .busy(busy)
    );

    typedef struct {
        logic [3:0] data;
        logic [3:0] flags;
        logic [3:0] count;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic       m_carry = 1'b0;
    logic [3:0] m_count = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] w, input bit gap);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
        if (gap) begin
            in_data = 4'hA;
            tick();
            tick();
        end
    endtask

    task automatic do_op(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input bit clr, input bit gap, input string tag);
        logic [4:0] s;
        exp_t       e;
        int         n;
        s = {1'b0, a} + {1'b0, b} + {4'b0, m_carry};
        e.data  = s[3:0];
        e.flags = {s[4], (a[3] == b[3]) && (s[3] != a[3]), s[3], s[3:0] == 4'h0};
        m_carry = clr ? 1'b0 : s[4];
        m_count = m_count + 4'd1;
        e.count = m_count;
        sb.push_back(e);

        send(op, gap);
        send(a, gap);
        send(b, 1'b0);
        chk({tag, "_exec_valid"}, {31'b0, res_valid}, 32'd0);
        chk({tag, "_exec_busy"}, {31'b0, busy}, 32'd1);
        chk({tag, "_exec_ready"}, {31'b0, in_ready}, 32'd0);
        chk({tag, "_opcode"}, {28'b0, alu_opcode}, {28'b0, op});
        chk({tag, "_a"}, {28'b0, alu_a}, {28'b0, a});
        chk({tag, "_b"}, {28'b0, alu_b}, {28'b0, b});

        clear_carry = clr;
        tick();
        clear_carry = 1'b0;
        n = 0;
        while (!res_valid && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 32'd0);
        e = sb.pop_front();
        chk({tag, "_data"}, {28'b0, res_data}, {28'b0, e.data});
        chk({tag, "_flags"}, {28'b0, res_flags}, {28'b0, e.flags});
        chk({tag, "_count"}, {28'b0, op_count}, {28'b0, e.count});
        chk({tag, "_carry_in"}, {31'b0, alu_carry_in}, {31'b0, m_carry});
    endtask

    task automatic release_res(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_rel_valid"}, {31'b0, res_valid}, 32'd0);
        chk({tag, "_rel_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_rel_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_carry_in", {31'b0, alu_carry_in}, 32'd0);
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_op_count", {28'b0, op_count}, 32'd0);
        chk("rst_opcode", {28'b0, alu_opcode}, 32'd0);

        do_op(4'h8, 4'h9, 4'h8, 1'b0, 1'b0, "op1");
        chk("op1_result_lit", {28'b0, res_data}, 32'h1);
        chk("op1_carry_flag", {31'b0, res_flags[3]}, 32'd1);

        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 4'h3;
            tick();
            chk("hold_valid", {31'b0, res_valid}, 32'd1);
            chk("hold_data", {28'b0, res_data}, 32'h1);
            chk("hold_a", {28'b0, alu_a}, 32'h9);
            chk("hold_opcode", {28'b0, alu_opcode}, 32'h8);
        end
        in_valid = 1'b0;
        release_res("op1");

        do_op(4'h3, 4'h2, 4'h5, 1'b0, 1'b1, "gap");
        release_res("gap");

        do_op(4'h1, 4'hF, 4'hF, 1'b1, 1'b0, "clr");
        chk("clr_flag_c", {31'b0, res_flags[3]}, 32'd1);
        release_res("clr");

        send(4'h5, 1'b0);
        send(4'h6, 1'b0);
        in_valid = 1'b1;
        in_data  = 4'h7;
        rst_n    = 1'b0;
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        chk("mrst_opcode", {28'b0, alu_opcode}, 32'd0);
        chk("mrst_a", {28'b0, alu_a}, 32'd0);
        chk("mrst_b", {28'b0, alu_b}, 32'd0);
        chk("mrst_res_data", {28'b0, res_data}, 32'd0);
        chk("mrst_res_flags", {28'b0, res_flags}, 32'd0);
        chk("mrst_op_count", {28'b0, op_count}, 32'd0);
        chk("mrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("mrst_busy", {31'b0, busy}, 32'd0);
        m_carry = 1'b0;
        m_count = '0;
        sb.delete();
        do_op(4'h2, 4'h4, 4'h3, 1'b0, 1'b0, "post_rst");
        release_res("post_rst");

        for (int i = 1; i < 16; i++) begin
            do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'b0, 1'b0, "wrap");
            release_res("wrap");
        end
        chk("wrap_count_zero", {28'b0, op_count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: W, default 4, datapath width of operands, opcode and result.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 in_data  in  W  load word: opcode, then operand A, then operand B.
REQ-005 in_valid  in  1  in_data valid.
REQ-006 in_ready  out  1  sequencer accepts in_data this cycle.
REQ-007 clear_carry  in  1  synchronous clear of the carry register.
REQ-008 alu_opcode, alu_a, alu_b  out  W each  registered opcode/operands driven to the downstream ALU.
REQ-009 alu_carry_in  out  1  carry register value driven to the ALU.
REQ-010 alu_result  in  W  ALU combinational result.
REQ-011 alu_carry_out, alu_overflow, alu_negative, alu_zero  in  1 each  ALU flags.
REQ-012 res_data  out  W  captured result.
REQ-013 res_flags  out  4  captured flags, bit3..0 = C,V,N,Z.
REQ-014 res_valid  out  1  res_data/res_flags valid.
REQ-015 res_ready  in  1  consumer accepts result.
REQ-016 op_count  out  W  completed-operation counter.
REQ-017 busy  out  1  high in any state other than LOAD_OP.

Function
REQ-018 FSM states LOAD_OP, LOAD_A, LOAD_B, EXEC, HOLD.
REQ-019 in_ready = 1 only in LOAD_OP, LOAD_A, LOAD_B; handshake = in_valid & in_ready at a rising edge.
REQ-020 LOAD_OP: handshake captures in_data into opcode register, next LOAD_A; no handshake, stay.
REQ-021 LOAD_A: handshake captures operand A, next LOAD_B; LOAD_B: captures operand B, next EXEC.
REQ-022 EXEC lasts exactly one cycle; at its closing edge res_data <= alu_result, res_flags <= {C,V,N,Z} from ALU, carry register <= alu_carry_out, op_count <= op_count+1 (wraps 2^W-1 -> 0), res_valid <= 1, next HOLD.
REQ-023 Latency: res_valid rises at the edge one cycle after the B handshake edge.
REQ-024 HOLD: res_valid = 1, outputs stable; res_valid & res_ready at an edge -> res_valid <= 0, next LOAD_OP; else stay indefinitely.
REQ-025 Opcode/operand registers hold value until overwritten by a new handshake; alu_* outputs always reflect these registers.
REQ-026 in_valid in EXEC/HOLD ignored; no data captured.
REQ-027 clear_carry = 1 at an edge forces carry register to 0; in the EXEC closing edge, clear_carry wins over alu_carry_out; res_flags still captures alu_carry_out.
REQ-028 res_ready outside HOLD has no effect.

Reset
REQ-029 rst_n = 0 at a rising edge, in any state including mid-load or HOLD: state <= LOAD_OP, opcode/A/B registers <= 0, carry register <= 0, res_data <= 0, res_flags <= 0, res_valid <= 0, op_count <= 0.
REQ-030 During reset cycle in_ready output follows state (1 after the reset edge); handshakes in the reset cycle are discarded.
REQ-031 After reset: in_ready = 1, busy = 0, alu_carry_in = 0.

Structure
REQ-032 Shared package alu_seq_pkg holds the state enum and flag bit-index constants (FLAG_C=3, FLAG_V=2, FLAG_N=1, FLAG_Z=0).
REQ-033 No sub-module; ALU instantiated alongside at the parent level, connected via alu_* ports.
REQ-034 Single always_ff for state/registers, one always_comb for next-state and in_ready/busy.

Verification (W=4)
REQ-035 Reset then load opcode 4'h8, A=4'h9, B=4'h8 back-to-back, ALU model adder -> res_valid one cycle after B edge, res_data=4'h1, C=1, op_count=1, alu_carry_in=1 afterward.
REQ-036 res_ready held low 5 cycles in HOLD -> res_valid and res_data stable; in_valid pulses ignored; res_ready=1 -> LOAD_OP next cycle.
REQ-037 in_valid gapped (1 cycle on, 2 off) during loads -> only handshake words captured; opcode/A/B equal the three sent words.
REQ-038 clear_carry=1 in EXEC with alu_carry_out=1 -> carry register 0, res_flags[3]=1.
REQ-039 rst_n=0 while in LOAD_B after A loaded -> all outputs at reset values, next load starts from opcode.
REQ-040 16 complete operations -> op_count wraps 4'hF -> 4'h0.
